// File: rtl/pe_stream_pkg.sv
// pe_stream_pkg: shared defaults and size helpers for the PE stream blocks
package pe_stream_pkg;
    localparam int AXIS_WIDTH_DEF         = 128;
    localparam int NUM_BRAM_ADDR_BITS_DEF = 7;
    localparam int OCC_W_DEF              = NUM_BRAM_ADDR_BITS_DEF + 2;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction
endpackage

// File: rtl/pe_sdp_ram.sv
// pe_sdp_ram: simple dual-port RAM, one write port, one registered read port
module pe_sdp_ram #(
    parameter int W = 128,
    parameter int A = 7
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [A-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         re_i,
    input  logic [A-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);
    logic [W-1:0] mem_q [0:(1<<A)-1];

    // Write port and enabled synchronous read; read data holds when not reading
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/pe_stream_rx_fifo.sv
// pe_stream_rx_fifo: elastic receive buffer with early ready and two-stage prefetch
module pe_stream_rx_fifo import pe_stream_pkg::*; #(
    parameter int AXIS_WIDTH         = AXIS_WIDTH_DEF,
    parameter int NUM_BRAM_ADDR_BITS = NUM_BRAM_ADDR_BITS_DEF,
    parameter int SLACK              = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [AXIS_WIDTH-1:0]         din,
    input  logic                          val_in,
    output logic                          ready_upward,
    output logic [AXIS_WIDTH-1:0]         dout,
    output logic                          val_out,
    input  logic                          ready_downward,
    output logic [NUM_BRAM_ADDR_BITS+1:0] occupancy,
    output logic                          overflow
);
    localparam int AW = NUM_BRAM_ADDR_BITS;
    localparam int DEPTH = depth_of(AW);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] READY_LIM = (AW+1)'(DEPTH - SLACK);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  rd_valid_q, rd_valid_d, val_out_q, val_out_d;
    logic                  rdy_q, rdy_d, ovf_q, ovf_d;
    logic [AXIS_WIDTH-1:0] dout_q, dout_d, rd_data;
    logic                  full, wr_en, rd_en, out_adv, ld;

    assign full    = cnt_q == DEPTH_C;
    assign wr_en   = ap_start && val_in && !full;
    assign out_adv = !val_out_q || ready_downward;
    assign ld      = ap_start && out_adv;
    assign rd_en   = ap_start && cnt_q != '0 && (!rd_valid_q || out_adv);

    pe_sdp_ram #(.W(AXIS_WIDTH), .A(AW)) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Next state: pointers wrap naturally, the read stage refills as it drains,
    // and ready looks at the post-edge RAM count so upstream sees it a cycle late
    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        val_out_d  = ld ? rd_valid_q : val_out_q;
        dout_d     = (ld && rd_valid_q) ? rd_data : dout_q;
        rd_valid_d = rd_en ? 1'b1 : (ld ? 1'b0 : rd_valid_q);
        rdy_d      = ap_start ? (cnt_d < READY_LIM) : rdy_q;
        ovf_d      = ovf_q || (ap_start && val_in && full);
    end

    // State registers with synchronous reset; RAM contents are left alone
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            val_out_q  <= 1'b0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            val_out_q  <= val_out_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ready_upward = rdy_q;
    assign dout         = dout_q;
    assign val_out      = val_out_q;
    assign overflow     = ovf_q;
    assign occupancy    = {1'b0, cnt_q} + (AW+2)'(rd_valid_q) + (AW+2)'(val_out_q);
endmodule

// File: tb/tb_pe_stream_rx_fifo.sv
// tb_pe_stream_rx_fifo: randomized self-checking bench against a queue-based model
module tb_pe_stream_rx_fifo;
    import pe_stream_pkg::*;
    localparam int W = AXIS_WIDTH_DEF;
    localparam int AB = NUM_BRAM_ADDR_BITS_DEF;
    localparam int DEPTH = depth_of(AB);
    localparam int SLACK = 4;
    localparam int OW = OCC_W_DEF;

    logic clk = 0, reset = 1, ap_start = 0, val_in = 0, ready_downward = 0;
    logic [W-1:0] din = '0, dout;
    logic ready_upward, val_out, overflow;
    logic [OW-1:0] occupancy;

    pe_stream_rx_fifo #(.AXIS_WIDTH(W), .NUM_BRAM_ADDR_BITS(AB), .SLACK(SLACK)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .din(din), .val_in(val_in),
        .ready_upward(ready_upward), .dout(dout), .val_out(val_out),
        .ready_downward(ready_downward), .occupancy(occupancy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0, n_hs = 0;
    // model: words waiting in RAM, the prefetched word, the presented word
    logic [W-1:0] m_ram[$], sb[$];
    logic m_rv = 0, m_ov = 0, m_rdy = 0, m_ovf = 0;
    logic [W-1:0] m_rd = '0, m_od = '0;
    logic hs;
    logic [W-1:0] hs_got, hs_exp;

    function automatic int m_occ();
        return m_ram.size() + int'(m_rv) + int'(m_ov);
    endfunction

    function automatic logic [OW+2:0] exp_vec();
        return {m_ov, m_rdy, OW'(m_occ()), m_ovf};
    endfunction

    function automatic logic m_empty();
        return m_occ() == 0;
    endfunction

    task automatic model_clear();
        m_ram = {}; sb = {};
        m_rv = 0; m_ov = 0; m_rdy = 0; m_ovf = 0; m_rd = '0; m_od = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1; ap_start = 1; val_in = 1; din = W'($urandom);
        repeat (n) @(posedge clk);
        #1 reset = 0; val_in = 0;
        model_clear();
    endtask

    // drive one cycle, record any handshake, advance the model, sample #1 after edge
    task automatic step(input logic ap, input logic vin, input logic [W-1:0] d, input logic rdy);
        logic wr, ord, rd;
        ap_start = ap; val_in = vin; din = d; ready_downward = rdy;
        hs = ap && val_out && rdy;
        hs_got = dout;
        hs_exp = ~dout;
        if (hs && sb.size() > 0) hs_exp = sb.pop_front();
        if (ap) begin
            wr = vin && m_ram.size() < DEPTH;
            if (vin && !wr) m_ovf = 1;
            ord = !m_ov || rdy;
            rd = m_ram.size() > 0 && (!m_rv || ord);
            if (ord) begin
                m_ov = m_rv;
                if (m_rv) m_od = m_rd;
            end
            if (rd) begin
                m_rv = 1;
                m_rd = m_ram.pop_front();
            end else if (ord) m_rv = 0;
            if (wr) begin
                m_ram.push_back(d);
                sb.push_back(d);
            end
            m_rdy = m_ram.size() < DEPTH - SLACK;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; ap_start = 1; val_in = 1; ready_downward = 0;
        for (int i = 0; i < 3; i++) begin
            din = W'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({val_out, ready_upward, occupancy, overflow, dout} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d got vo=%b ru=%b occ=%0d ovf=%b dout=%h exp all zero",
                         i, val_out, ready_upward, occupancy, overflow, dout);
            end
        end
        reset = 0;
        model_clear();
        #1;
        checks++;
        if (ready_upward !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_low got %b exp 0", ready_upward);
        end
        step(1, 0, '0, 0);
        checks++;
        if (ready_upward !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_high got %b exp 1", ready_upward);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) begin
            step(1, i == 0, W'(8'hA5), 1);
            checks++;
            if ({val_out, ready_upward, occupancy, overflow} !== exp_vec()) begin
                fails++;
                $display("FAIL single_status got %h exp %h", {val_out, ready_upward, occupancy, overflow}, exp_vec());
            end
            if (hs) begin
                checks++; n_hs++;
                if (hs_got !== hs_exp) begin
                    fails++;
                    $display("FAIL single_order got %h exp %h", hs_got, hs_exp);
                end
            end
            checks++;
            if (val_out !== (i == 2) || (i == 2 && dout !== W'(8'hA5)) || (i == 3 && occupancy !== '0)) begin
                fails++;
                $display("FAIL single_latency cycle %0d got vo=%b dout=%h occ=%0d exp vo=%b dout=a5 occ=0",
                         i, val_out, dout, occupancy, i == 2);
            end
        end
    endtask

    task automatic test_fill();
        int h0 = n_hs;
        logic done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (i < 132) step(1, 1, W'(i), 0);
            else step(1, 0, '0, 1);
            checks++;
            if ({val_out, ready_upward, occupancy, overflow} !== exp_vec()) begin
                fails++;
                $display("FAIL fill_status cycle %0d got %h exp %h", i, {val_out, ready_upward, occupancy, overflow}, exp_vec());
            end
            if (m_ov) begin
                checks++;
                if (dout !== m_od) begin
                    fails++;
                    $display("FAIL fill_dout got %h exp %h", dout, m_od);
                end
            end
            if (hs) begin
                checks++; n_hs++;
                if (hs_got !== hs_exp) begin
                    fails++;
                    $display("FAIL fill_order got %h exp %h", hs_got, hs_exp);
                end
            end
            done = i >= 132 && m_empty();
        end
        checks++;
        if (!done || overflow !== 1'b1 || n_hs - h0 != DEPTH + 2) begin
            fails++;
            $display("FAIL fill_summary got done=%b ovf=%b emerged=%0d exp done=1 ovf=1 emerged=%0d",
                     done, overflow, n_hs - h0, DEPTH + 2);
        end
    endtask

    task automatic test_stream();
        int h0 = n_hs, sent = 0, win = 0;
        logic done = 0, vin, rdy;
        for (int c = 0; c < 30000 && !done; c++) begin
            logic in_win = c >= 200 && c < 260;
            vin = (sent < 2000) && ready_upward && (in_win || $urandom_range(1, 0) == 1);
            rdy = in_win || $urandom_range(1, 0) == 1;
            step(1, vin, W'(sent), rdy);
            if (vin) sent++;
            if (in_win && c >= 203 && hs) win++;
            checks++;
            if ({val_out, ready_upward, occupancy, overflow} !== exp_vec()) begin
                fails++;
                $display("FAIL stream_status cycle %0d got %h exp %h", c, {val_out, ready_upward, occupancy, overflow}, exp_vec());
            end
            if (m_ov) begin
                checks++;
                if (dout !== m_od) begin
                    fails++;
                    $display("FAIL stream_dout got %h exp %h", dout, m_od);
                end
            end
            if (hs) begin
                checks++; n_hs++;
                if (hs_got !== hs_exp) begin
                    fails++;
                    $display("FAIL stream_order got %h exp %h", hs_got, hs_exp);
                end
            end
            done = sent >= 2000 && m_empty();
        end
        checks++;
        if (!done || overflow !== 1'b0 || n_hs - h0 != 2000 || win != 57) begin
            fails++;
            $display("FAIL stream_summary got done=%b ovf=%b words=%0d full_rate=%0d exp done=1 ovf=0 words=2000 full_rate=57",
                     done, overflow, n_hs - h0, win);
        end
    endtask

    task automatic test_freeze();
        int sent = 0;
        logic done = 0, ap, vin;
        logic [W+OW+1:0] snap = '0;
        for (int c = 0; c < 2000 && !done; c++) begin
            ap = !(c >= 30 && c < 40);
            if (c == 30) snap = {m_od, m_ov, OW'(m_occ()), m_rdy};
            vin = !ap || (c < 60 && ready_upward);
            step(ap, vin, W'(sent + 5000), ap ? $urandom_range(1, 0) == 1 : c[0]);
            if (ap && vin) sent++;
            if (!ap) begin
                checks++;
                if ({dout, val_out, occupancy, ready_upward} !== snap) begin
                    fails++;
                    $display("FAIL freeze_hold cycle %0d got %h exp %h", c, {dout, val_out, occupancy, ready_upward}, snap);
                end
            end
            checks++;
            if ({val_out, ready_upward, occupancy, overflow} !== exp_vec()) begin
                fails++;
                $display("FAIL freeze_status cycle %0d got %h exp %h", c, {val_out, ready_upward, occupancy, overflow}, exp_vec());
            end
            if (hs) begin
                checks++; n_hs++;
                if (hs_got !== hs_exp) begin
                    fails++;
                    $display("FAIL freeze_order got %h exp %h", hs_got, hs_exp);
                end
            end
            done = c >= 60 && m_empty();
        end
        checks++;
        if (!done || sb.size() != 0) begin
            fails++;
            $display("FAIL freeze_drain got done=%b pending=%0d exp done=1 pending=0", done, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic first = 1, reached = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            step(1, 1, W'($urandom), 0);
            reached = m_occ() == 50;
        end
        checks++;
        if (!reached || occupancy !== OW'(50)) begin
            fails++;
            $display("FAIL reset_mid_fill got occ=%0d exp 50", occupancy);
        end
        reset = 1; ap_start = 1; val_in = 1;
        @(posedge clk);
        #1 reset = 0;
        model_clear();
        checks++;
        if ({val_out, ready_upward, occupancy, overflow, dout} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs got vo=%b ru=%b occ=%0d ovf=%b dout=%h exp all zero",
                     val_out, ready_upward, occupancy, overflow, dout);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, i == 0, W'(1), 1);
            checks++;
            if ({val_out, ready_upward, occupancy, overflow} !== exp_vec()) begin
                fails++;
                $display("FAIL reset_mid_status got %h exp %h", {val_out, ready_upward, occupancy, overflow}, exp_vec());
            end
            if (hs && first) begin
                first = 0;
                checks++; n_hs++;
                if (hs_got !== W'(1)) begin
                    fails++;
                    $display("FAIL reset_mid_first got %h exp 1", hs_got);
                end
            end
        end
        checks++;
        if (first) begin
            fails++;
            $display("FAIL reset_mid_emerge got no word exp word 1");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        do_reset(2);
        step(1, 0, '0, 0);
        test_stream();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
